// File: rtl/paillier_lite_regs.sv
// AXI4-Lite control/status register block for the Paillier core (CTRL, STATUS, BLOCK_CNT, SCRATCH).
// Optional interrupt output and CTRL.IRQ_EN bit when PAILLIER_LITE_IRQ_EN is defined.
module paillier_lite_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            start_o,
  output logic [1:0]                      mode_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   block_cnt_o,
  input  logic                            busy_i,
  input  logic                            done_i
`ifdef PAILLIER_LITE_IRQ_EN
  ,
  output logic                            irq_o
`endif
);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic                          wr_hs, rd_hs;
  logic [2:0]                    wr_idx, rd_idx;
  logic [1:0]                    bresp_q, rresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rd_word;
  logic                          rd_err;
  logic [1:0]                    mode_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] blk_q, scr_q;
  logic                          done_q, start_q;
  logic                          unused_addr_bits;
`ifdef PAILLIER_LITE_IRQ_EN
  logic                          irq_en_q;
`endif

  assign wr_idx           = S_AXI_AWADDR[4:2];
  assign rd_idx           = S_AXI_ARADDR[4:2];
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Handshakes are combinational off the idle state; reset gating keeps READY low while reset is held.
  always_comb begin
    w_state_nxt = w_state;
    wr_hs       = 1'b0;
    case (w_state)
      W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_ARESET) begin
        wr_hs       = 1'b1;
        w_state_nxt = W_RESP;
      end
      W_RESP: if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    rd_hs       = 1'b0;
    case (r_state)
      R_IDLE: if (S_AXI_ARVALID && !S_AXI_ARESET) begin
        rd_hs       = 1'b1;
        r_state_nxt = R_DATA;
      end
      R_DATA: if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (rd_idx)
      3'd0: begin
        rd_word[2:1] = mode_q;
`ifdef PAILLIER_LITE_IRQ_EN
        rd_word[3]   = irq_en_q;
`endif
      end
      3'd1:    rd_word[1:0] = {done_q, busy_i};
      3'd2:    rd_word = blk_q;
      3'd3:    rd_word = scr_q;
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      bresp_q  <= '0;
      rresp_q  <= '0;
      rdata_q  <= '0;
      mode_q   <= '0;
      blk_q    <= '0;
      scr_q    <= '0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
`ifdef PAILLIER_LITE_IRQ_EN
      irq_en_q <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      if (rd_hs) begin
        rdata_q <= rd_word;
        rresp_q <= rd_err ? 2'b10 : 2'b00;
      end
      if (wr_hs) begin
        bresp_q <= wr_idx[2] ? 2'b10 : 2'b00;
        case (wr_idx)
          3'd0: if (S_AXI_WSTRB[0]) begin
            mode_q <= S_AXI_WDATA[2:1];
`ifdef PAILLIER_LITE_IRQ_EN
            irq_en_q <= S_AXI_WDATA[3];
`endif
            if (S_AXI_WDATA[0] && !busy_i) start_q <= 1'b1;
          end
          3'd2: for (int unsigned i = 0; i < 4; i++)
            if (S_AXI_WSTRB[i]) blk_q[8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
          3'd3: for (int unsigned i = 0; i < 4; i++)
            if (S_AXI_WSTRB[i]) scr_q[8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
          default: ;
        endcase
      end
      // A done_i pulse coinciding with the W1C write must not be lost.
      if (done_i)
        done_q <= 1'b1;
      else if (wr_hs && wr_idx == 3'd1 && S_AXI_WSTRB[0] && S_AXI_WDATA[1])
        done_q <= 1'b0;
    end
  end

`ifdef PAILLIER_LITE_IRQ_EN
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) irq_o <= 1'b0;
    else              irq_o <= done_q & irq_en_q;
  end
`endif

  assign S_AXI_AWREADY = wr_hs;
  assign S_AXI_WREADY  = wr_hs;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = rd_hs;
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign start_o       = start_q;
  assign mode_o        = mode_q;
  assign block_cnt_o   = blk_q;

endmodule

// File: tb/tb_paillier_lite_regs.sv
// Self-checking bench for paillier_lite_regs: vector table, corner-case sequences, randomized ops vs. a register-map model.
module tb_paillier_lite_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, start_o;
  logic [1:0]  bresp, rresp, mode_o;
  logic [31:0] rdata, block_cnt_o;
  logic        busy_i = 1'b0, done_i = 1'b0;
`ifdef PAILLIER_LITE_IRQ_EN
  logic        irq_o;
`endif

  int checks = 0, failures = 0, start_cnt = 0;

  always #5 clk = ~clk;

  paillier_lite_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .start_o(start_o), .mode_o(mode_o), .block_cnt_o(block_cnt_o),
    .busy_i(busy_i), .done_i(done_i)
`ifdef PAILLIER_LITE_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  always @(negedge clk) if (start_o) start_cnt++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit ok = 0;
    resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1; break; end
    end
    if (!ok) chk("write_accept_timeout", 0, 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; bready = 1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bvalid) begin resp = bresp; ok = 1; break; end
    end
    if (!ok) chk("bvalid_timeout", 0, 1);
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ok = 0;
    d = 'x; resp = 2'bxx;
    araddr = a; arvalid = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    if (!ok) chk("read_accept_timeout", 0, 1);
    @(posedge clk); #1;
    arvalid = 0; rready = 1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rvalid) begin d = rdata; resp = rresp; ok = 1; break; end
    end
    if (!ok) chk("rvalid_timeout", 0, 1);
    @(posedge clk); #1;
    rready = 0;
  endtask

  // Behavioural register-map model
  logic [1:0]  m_mode;
  logic        m_irq_en, m_done;
  logic [31:0] m_blk, m_scr;
  int          m_starts;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_irq_en = 0; m_done = 0; m_blk = 0; m_scr = 0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic busy, output logic [1:0] resp);
    int idx = int'(a) / 4;
    resp = (idx < 4) ? 2'b00 : 2'b10;
    if (idx == 0 && s[0]) begin
      m_mode = d[2:1];
`ifdef PAILLIER_LITE_IRQ_EN
      m_irq_en = d[3];
`endif
      if (d[0] && !busy) m_starts++;
    end
    if (idx == 1 && s[0] && d[1]) m_done = 0;
    if (idx == 2) m_blk = merge(m_blk, d, s);
    if (idx == 3) m_scr = merge(m_scr, d, s);
  endtask

  task automatic model_read(input logic [4:0] a, input logic busy,
                            output logic [31:0] d, output logic [1:0] resp);
    int idx = int'(a) / 4;
    resp = 2'b00;
    case (idx)
      0: d = 32'(m_mode) * 2 + 32'(m_irq_en) * 8;
      1: d = 32'(m_done) * 2 + 32'(busy);
      2: d = m_blk;
      3: d = m_scr;
      default: begin d = 0; resp = 2'b10; end
    endcase
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [31:0] d, ed, held;
    logic [1:0]  r, er;
    logic [4:0]  a;
    logic [3:0]  s;
    bit          stable;
    int          st0;

`ifdef PAILLIER_LITE_IRQ_EN
    localparam logic [31:0] CTRL_E = 32'hE;
`else
    localparam logic [31:0] CTRL_E = 32'h6;
`endif
    tbl[0]  = '{1, 5'h00, 32'h0000_0005, 4'hF, 32'h0, 2'b00};
    tbl[1]  = '{0, 5'h00, 32'h0, 4'h0, 32'h0000_0004, 2'b00};
    tbl[2]  = '{1, 5'h0C, 32'hDEAD_BEEF, 4'b0011, 32'h0, 2'b00};
    tbl[3]  = '{0, 5'h0C, 32'h0, 4'h0, 32'h0000_BEEF, 2'b00};
    tbl[4]  = '{1, 5'h08, 32'h1234_5678, 4'hF, 32'h0, 2'b00};
    tbl[5]  = '{0, 5'h08, 32'h0, 4'h0, 32'h1234_5678, 2'b00};
    tbl[6]  = '{1, 5'h08, 32'hAABB_CCDD, 4'b0100, 32'h0, 2'b00};
    tbl[7]  = '{0, 5'h08, 32'h0, 4'h0, 32'h12BB_5678, 2'b00};
    tbl[8]  = '{0, 5'h18, 32'h0, 4'h0, 32'h0, 2'b10};
    tbl[9]  = '{1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10};
    tbl[10] = '{0, 5'h0C, 32'h0, 4'h0, 32'h0000_BEEF, 2'b00};
    tbl[11] = '{0, 5'h04, 32'h0, 4'h0, 32'h0, 2'b00};
    tbl[12] = '{1, 5'h00, 32'h0000_000E, 4'hF, 32'h0, 2'b00};
    tbl[13] = '{0, 5'h00, 32'h0, 4'h0, CTRL_E, 2'b00};
    tbl[14] = '{0, 5'h10, 32'h0, 4'h0, 32'h0, 2'b10};
    tbl[15] = '{1, 5'h04, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b00};
    tbl[16] = '{0, 5'h04, 32'h0, 4'h0, 32'h0, 2'b00};

    // Reset state with request valids asserted
    awvalid = 1; wvalid = 1; arvalid = 1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, start_o, mode_o, block_cnt_o},
        '0);
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
        chk($sformatf("vec%0d_bresp", i), r, tbl[i].exp_resp);
      end else begin
        axi_read(tbl[i].addr, d, r);
        chk($sformatf("vec%0d_rdata", i), d, tbl[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), r, tbl[i].exp_resp);
      end
    end
    chk("table_start_pulses", start_cnt, 1);
    chk("table_mode_o", mode_o, 2'b11);
    chk("table_block_cnt_o", block_cnt_o, 32'h12BB_5678);

    // START while busy: ignored, MODE still taken
    busy_i = 1;
    axi_write(5'h00, 32'h3, 4'hF, r);
    busy_i = 0;
    repeat (2) @(posedge clk); #1;
    chk("busy_start_ignored", start_cnt, 1);
    chk("busy_mode_o", mode_o, 2'b01);
    axi_read(5'h00, d, r);
    chk("busy_ctrl_read", d, 32'h2);

    // DONE sticky and W1C
    done_i = 1; @(posedge clk); #1; done_i = 0;
    axi_read(5'h04, d, r);
    chk("done_set", d, 32'h2);
    axi_write(5'h04, 32'h2, 4'hF, r);
    axi_read(5'h04, d, r);
    chk("done_cleared", d, 32'h0);
    done_i = 1; @(posedge clk); #1; done_i = 0;
    awaddr = 5'h04; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1; done_i = 1;
    @(negedge clk);
    chk("w1c_race_accept", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; done_i = 0; bready = 1;
    @(posedge clk); #1; bready = 0;
    axi_read(5'h04, d, r);
    chk("done_set_wins", d, 32'h2);
    axi_write(5'h04, 32'h2, 4'hF, r);

    // BREADY held low on an unmapped write
    awaddr = 5'h14; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    stable = 1;
    repeat (10) begin
      @(negedge clk);
      if (!(bvalid === 1'b1 && bresp === 2'b10)) stable = 0;
    end
    chk("bvalid_hold", stable, 1);
    bready = 1; @(posedge clk); #1; bready = 0;
    @(negedge clk);
    chk("bvalid_drop", bvalid, 0);
    @(posedge clk); #1;

    // RREADY held low
    araddr = 5'h08; arvalid = 1;
    @(posedge clk); #1; arvalid = 0;
    stable = 1;
    repeat (10) begin
      @(negedge clk);
      if (!(rvalid === 1'b1 && rdata === 32'h12BB_5678 && rresp === 2'b00)) stable = 0;
    end
    chk("rvalid_hold", stable, 1);
    rready = 1; @(posedge clk); #1; rready = 0;

    // AWVALID five cycles ahead of WVALID
    awaddr = 5'h0C; wdata = 32'h1111_1111; wstrb = 4'hF; awvalid = 1;
    stable = 1;
    repeat (5) begin
      @(negedge clk);
      if (awready !== 1'b0 || wready !== 1'b0) stable = 0;
      @(posedge clk); #1;
    end
    chk("aw_only_not_accepted", stable, 1);
    wvalid = 1;
    @(negedge clk);
    chk("aw_w_accepted", {awready, wready}, 2'b11);
    @(posedge clk); #1; awvalid = 0; wvalid = 0; bready = 1;
    @(posedge clk); #1; bready = 0;

    // Simultaneous read and write of SCRATCH
    awaddr = 5'h0C; wdata = 32'h2222_2222; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 5'h0C; arvalid = 1;
    @(negedge clk);
    chk("simul_readys", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    @(negedge clk);
    chk("simul_pre_write_value", rdata, 32'h1111_1111);
    @(posedge clk); #1; bready = 0; rready = 0;
    axi_read(5'h0C, d, r);
    chk("simul_post_write_value", d, 32'h2222_2222);

`ifdef PAILLIER_LITE_IRQ_EN
    axi_write(5'h00, 32'h8, 4'hF, r);
    done_i = 1; @(posedge clk); #1; done_i = 0;
    @(negedge clk);
    chk("irq_lag", irq_o, 0);
    @(negedge clk);
    chk("irq_high", irq_o, 1);
    @(posedge clk); #1;
    axi_write(5'h04, 32'h2, 4'hF, r);
    repeat (2) @(posedge clk); #1;
    chk("irq_cleared", irq_o, 0);
`endif

    // Reset during a pending write response
    awaddr = 5'h08; wdata = 32'h5555_5555; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("abort_bvalid_before", bvalid, 1);
    #2 rst = 1; #1;
    chk("abort_async_clear", {bvalid, block_cnt_o, mode_o}, '0);
    @(negedge clk); rst = 0;
    stable = 1;
    repeat (3) begin
      @(negedge clk);
      if (bvalid !== 1'b0 || rvalid !== 1'b0) stable = 0;
    end
    chk("abort_no_response", stable, 1);
    @(posedge clk); #1;
    axi_read(5'h0C, d, r);
    chk("abort_scratch_reset", d, 32'h0);

    // Randomized accesses against the model
    model_reset();
    m_starts = 0;
    st0 = start_cnt;
    for (int n = 0; n < 150; n++) begin
      a = 5'(($urandom_range(0, 7)) * 4);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      busy_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        model_write(a, d, s, busy_i, er);
        axi_write(a, d, s, r);
        chk($sformatf("rnd%0d_bresp", n), r, er);
      end else begin
        model_read(a, busy_i, ed, er);
        axi_read(a, held, r);
        chk($sformatf("rnd%0d_read", n), {r, held}, {er, ed});
      end
    end
    busy_i = 0;
    repeat (2) @(posedge clk); #1;
    chk("rnd_start_pulses", start_cnt - st0, m_starts);
    chk("rnd_outputs", {mode_o, block_cnt_o}, {m_mode, m_blk});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
